// File: rtl/camera_pkg.sv
// camera_pkg: capture FSM state encoding and default frame geometry shared with camera_mock
package camera_pkg;
    localparam int ROWS_DEF   = 12;
    localparam int COLS_DEF   = 12;
    localparam int PIX_W_DEF  = 10;
    localparam int ADDR_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, ARM, FRAME, DONE} state_t;
endpackage

// File: rtl/camera_capture_ctrl_if.sv
// camera_capture_ctrl_if: camera pixel stream in, frame-buffer write port out
interface camera_capture_ctrl_if #(
    parameter int PIX_W  = camera_pkg::PIX_W_DEF,
    parameter int ADDR_W = camera_pkg::ADDR_W_DEF
);
    logic              cam_vsync;
    logic              cam_href;
    logic [PIX_W-1:0]  cam_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    modport master (output cam_vsync, cam_href, cam_data, input wr_en, wr_addr, wr_data);
    modport slave (input cam_vsync, cam_href, cam_data, output wr_en, wr_addr, wr_data);
endinterface

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: registers the camera pins once and flags vsync rise / href fall
module cam_sync_edge import camera_pkg::*; #(
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vsync,
    input  logic             href,
    input  logic [PIX_W-1:0] data,
    output logic             vs_q,
    output logic             href_q,
    output logic [PIX_W-1:0] data_q,
    output logic             vs_rise,
    output logic             href_fall
);
    logic vs_qq, href_qq;
    always_ff @(posedge clk) begin
        if (rst) begin
            {vs_q, vs_qq, href_q, href_qq} <= '0;
            data_q <= '0;
        end else begin
            vs_q    <= vsync;
            vs_qq   <= vs_q;
            href_q  <= href;
            href_qq <= href_q;
            data_q  <= data;
        end
    end
    assign vs_rise   = vs_q & ~vs_qq;
    assign href_fall = href_qq & ~href_q;
endmodule

// File: rtl/camera_capture_ctrl.sv
// camera_capture_ctrl: arms on request, captures whole frames into addressed writes, checks geometry
module camera_capture_ctrl import camera_pkg::*; #(
    parameter int ROWS   = ROWS_DEF,
    parameter int COLS   = COLS_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cap_start,
    input  logic [2:0] cap_frames,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] frame_idx,
    camera_capture_ctrl_if.slave bus
);
    localparam int RW = $clog2(ROWS + 1);
    localparam int CW = $clog2(COLS + 1);
    state_t state, state_n;
    logic vs_q, href_q, vs_rise, href_fall;
    logic [PIX_W-1:0] data_q;
    logic [2:0] frames;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic seen, accept, in_frame, px, in_row, last_row, last_px, last_frame, frame_end, wr, bad;
    logic wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0] wr_data;

    cam_sync_edge #(.PIX_W(PIX_W)) u_sync (
        .clk       (clk),
        .rst       (rst),
        .vsync     (bus.cam_vsync),
        .href      (bus.cam_href),
        .data      (bus.cam_data),
        .vs_q      (vs_q),
        .href_q    (href_q),
        .data_q    (data_q),
        .vs_rise   (vs_rise),
        .href_fall (href_fall)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // An early vsync both ends the current frame and starts the next one.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? ARM : IDLE;
            ARM:     state_n = vs_rise ? FRAME : ARM;
            FRAME:   state_n = !frame_end ? FRAME : last_frame ? DONE : vs_rise ? FRAME : ARM;
            default: state_n = IDLE;
        endcase
        if (abort) state_n = IDLE;
    end

    always_comb begin
        accept     = state == IDLE && cap_start && cap_frames != 3'd0 && !abort;
        in_frame   = state == FRAME;
        px         = in_frame && href_q && !vs_q;
        in_row     = col < CW'(COLS);
        last_row   = row == RW'(ROWS - 1);
        last_px    = px && in_row && col == CW'(COLS - 1) && last_row;
        last_frame = frame_idx == frames - 3'd1;
        frame_end  = last_px || (in_frame && href_fall && last_row) || (in_frame && vs_rise);
        wr         = px && in_row && !abort;
        bad        = in_frame && ((href_q && vs_q) || (px && !in_row) ||
                                  (href_fall && col != CW'(COLS)) || vs_rise);
        busy       = state != IDLE;
        done       = state == DONE;
    end

    // frame_idx advances on the vsync that opens each frame after the first.
    always_ff @(posedge clk) begin
        if (rst) begin
            frames    <= '0;
            frame_idx <= '0;
            seen      <= 1'b0;
            err       <= 1'b0;
            row       <= '0;
            col       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
        end else begin
            wr_en <= wr;
            if (wr) begin
                wr_addr <= ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
                wr_data <= data_q;
            end
            if (accept) begin
                frames    <= cap_frames;
                frame_idx <= '0;
                seen      <= 1'b0;
                err       <= 1'b0;
            end else if (bad && !abort) err <= 1'b1;
            if (vs_rise && state_n == FRAME) begin
                frame_idx <= frame_idx + 3'(seen);
                seen      <= 1'b1;
                row       <= '0;
                col       <= '0;
            end else if (px) col <= in_row ? col + 1'b1 : col;
            else if (in_frame && href_fall) begin
                row <= row + 1'b1;
                col <= '0;
            end
        end
    end

    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_addr;
    assign bus.wr_data = wr_data;
endmodule

// File: tb/tb_camera_capture_ctrl.sv
// tb_camera_capture_ctrl: directed 12x12 camera scenarios against hand-computed write streams
module tb_camera_capture_ctrl;
    import camera_pkg::*;
    logic clk = 0, rst = 1, cap_start = 0, abort = 0;
    logic [2:0] cap_frames = 0;
    logic busy, done, err;
    logic [2:0] frame_idx;
    int chk_cnt = 0, pass_cnt = 0, cyc = 0, mf = 0, px_cyc = 0, done_cyc = 0, done_cnt = 0;
    logic prev_done = 0, busy_after = 0;
    typedef struct {logic [15:0] a; logic [9:0] d; logic [2:0] f; logic dn;} wr_t;
    wr_t wq[$];

    camera_capture_ctrl_if bus ();
    camera_capture_ctrl dut (
        .clk(clk), .rst(rst), .cap_start(cap_start), .cap_frames(cap_frames), .abort(abort),
        .busy(busy), .done(done), .err(err), .frame_idx(frame_idx), .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // write recorder: every strobe with its frame index and done flag
    always @(negedge clk) begin
        if (bus.wr_en) wq.push_back('{bus.wr_addr, bus.wr_data, frame_idx, done});
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (prev_done) busy_after <= busy;
        prev_done <= done;
    end

    function automatic logic [9:0] pix(int f, int r, int c);
        return 10'((f * 97 + r * 12 + c) % 1024);
    endfunction

    // camera_mock: vsync 1 cycle, 1-cycle gaps; optional short/long row and control pulses
    task automatic drive_frame(input int sr, input int lr, input int st, input int ab, input int rs);
        @(negedge clk); bus.cam_vsync = 1;
        @(negedge clk); bus.cam_vsync = 0;
        for (int r = 0; r < 12; r++) begin
            int len;
            len = (r == sr) ? 11 : (r == lr) ? 13 : 12;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                bus.cam_href = 1;
                bus.cam_data = pix(mf, r, c);
                cap_start = (r == st && c == 0);
                abort = (r == ab && c == 3);
                rst = (r == rs && c == 5);
                if (r == 11 && c == len - 1) px_cyc = cyc;
            end
            @(negedge clk);
            bus.cam_href = 0; bus.cam_data = '0; cap_start = 0; abort = 0; rst = 0;
        end
        @(negedge clk);
        mf++;
    endtask

    task automatic pulse_start(input logic [2:0] n, input logic ab);
        @(negedge clk); cap_frames = n; cap_start = 1; abort = ab;
        @(negedge clk); cap_start = 0; abort = 0;
    endtask

    task automatic test_reset;
        bus.cam_vsync = 0; bus.cam_href = 0; bus.cam_data = '0;
        rst = 1;
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk_cnt++;
        if ({busy, done, err, frame_idx, bus.wr_en, bus.wr_addr, bus.wr_data} !== 33'd0)
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b idx=%0d wr_en=%b addr=%0d data=%0d want all 0",
                     busy, done, err, frame_idx, bus.wr_en, bus.wr_addr, bus.wr_data);
        else pass_cnt++;
    endtask

    task automatic test_single_frame;
        int n0, d0, b, bad;
        n0 = wq.size(); d0 = done_cnt; b = mf + 1; bad = 0;
        cap_frames = 1;
        drive_frame(-1, -1, 4, -1, -1);
        drive_frame(-1, -1, -1, -1, -1);
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (wq.size() - n0 !== 144) $display("FAIL single_count: got %0d want 144", wq.size() - n0);
        else pass_cnt++;
        for (int i = 0; i < 144 && n0 + i < wq.size(); i++)
            if (wq[n0+i].a !== 16'(i) || wq[n0+i].d !== pix(b, i / 12, i % 12) ||
                wq[n0+i].f !== 3'd0 || wq[n0+i].dn !== (i == 143)) bad++;
        chk_cnt++;
        if (bad !== 0) $display("FAIL single_stream: got %0d bad writes want 0", bad);
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt - d0 !== 1) $display("FAIL single_done: got %0d pulses want 1", done_cnt - d0);
        else pass_cnt++;
        chk_cnt++;
        if (done_cyc !== px_cyc + 2) $display("FAIL single_latency: got done at %0d want %0d", done_cyc, px_cyc + 2);
        else pass_cnt++;
        chk_cnt++;
        if (busy_after !== 1'b0) $display("FAIL single_busy_fall: got %b want 0", busy_after);
        else pass_cnt++;
        chk_cnt++;
        if ({busy, err} !== 2'b00) $display("FAIL single_idle: got busy=%b err=%b want 0 0", busy, err);
        else pass_cnt++;
    endtask

    task automatic test_multi_frame;
        int n0, d0, b, bad;
        n0 = wq.size(); d0 = done_cnt; b = mf; bad = 0;
        pulse_start(3, 0);
        chk_cnt++;
        if (busy !== 1'b1) $display("FAIL multi_busy_rise: got %b want 1", busy);
        else pass_cnt++;
        repeat (3) drive_frame(-1, -1, -1, -1, -1);
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (wq.size() - n0 !== 432) $display("FAIL multi_count: got %0d want 432", wq.size() - n0);
        else pass_cnt++;
        for (int i = 0; i < 432 && n0 + i < wq.size(); i++)
            if (wq[n0+i].a !== 16'(i % 144) || wq[n0+i].d !== pix(b + i / 144, (i % 144) / 12, i % 12) ||
                wq[n0+i].f !== 3'(i / 144) || wq[n0+i].dn !== (i == 431)) bad++;
        chk_cnt++;
        if (bad !== 0) $display("FAIL multi_stream: got %0d bad writes want 0", bad);
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt - d0 !== 1) $display("FAIL multi_done: got %0d pulses want 1", done_cnt - d0);
        else pass_cnt++;
        chk_cnt++;
        if (frame_idx !== 3'd2) $display("FAIL multi_idx: got %0d want 2", frame_idx);
        else pass_cnt++;
    endtask

    task automatic test_short_row;
        int n0, d0;
        n0 = wq.size(); d0 = done_cnt;
        pulse_start(1, 0);
        drive_frame(5, -1, -1, -1, -1);
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (wq.size() - n0 !== 143) $display("FAIL short_count: got %0d want 143", wq.size() - n0);
        else pass_cnt++;
        chk_cnt++;
        if (wq.size() - n0 >= 143 && (wq[n0+70].a !== 16'd70 || wq[n0+71].a !== 16'd72 ||
            wq[n0+142].a !== 16'd143 || wq[n0+142].dn !== 1'b1))
            $display("FAIL short_addr: got %0d %0d %0d done=%b want 70 72 143 done=1",
                     wq[n0+70].a, wq[n0+71].a, wq[n0+142].a, wq[n0+142].dn);
        else pass_cnt++;
        chk_cnt++;
        if (err !== 1'b1) $display("FAIL short_err: got %b want 1", err);
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt - d0 !== 1) $display("FAIL short_done: got %0d pulses want 1", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_ignored;
        pulse_start(0, 0);
        chk_cnt++;
        if ({busy, err} !== 2'b01) $display("FAIL zero_frames: got busy=%b err=%b want 0 1", busy, err);
        else pass_cnt++;
        pulse_start(1, 1);
        chk_cnt++;
        if ({busy, err} !== 2'b01) $display("FAIL abort_with_start: got busy=%b err=%b want 0 1", busy, err);
        else pass_cnt++;
    endtask

    task automatic test_long_row_abort;
        int n0, d0, b;
        n0 = wq.size(); d0 = done_cnt; b = mf;
        pulse_start(2, 0);
        chk_cnt++;
        if (err !== 1'b0) $display("FAIL accept_clears_err: got %b want 0", err);
        else pass_cnt++;
        drive_frame(-1, 2, -1, 7, -1);
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (wq.size() - n0 !== 86) $display("FAIL abort_count: got %0d want 86", wq.size() - n0);
        else pass_cnt++;
        chk_cnt++;
        if (wq.size() - n0 >= 37 && (wq[n0+36].a !== 16'd36 || wq[n0+36].d !== pix(b, 3, 0)))
            $display("FAIL long_skip: got addr=%0d data=%0d want 36 %0d", wq[n0+36].a, wq[n0+36].d, pix(b, 3, 0));
        else pass_cnt++;
        chk_cnt++;
        if ({busy, err} !== 2'b01) $display("FAIL abort_state: got busy=%b err=%b want 0 1", busy, err);
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt - d0 !== 0) $display("FAIL abort_done: got %0d pulses want 0", done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_restart;
        int n0, d0, bad;
        n0 = wq.size(); d0 = done_cnt; bad = 0;
        pulse_start(1, 0);
        chk_cnt++;
        if (err !== 1'b0) $display("FAIL restart_err: got %b want 0", err);
        else pass_cnt++;
        drive_frame(-1, -1, -1, -1, -1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 144 && n0 + i < wq.size(); i++)
            if (wq[n0+i].a !== 16'(i) || wq[n0+i].dn !== (i == 143)) bad++;
        chk_cnt++;
        if (wq.size() - n0 !== 144 || bad !== 0 || done_cnt - d0 !== 1)
            $display("FAIL restart_capture: got %0d writes %0d bad %0d done want 144 0 1",
                     wq.size() - n0, bad, done_cnt - d0);
        else pass_cnt++;
    endtask

    task automatic test_start_while_busy;
        int n0, d0, bad;
        n0 = wq.size(); d0 = done_cnt; bad = 0;
        pulse_start(1, 0);
        cap_frames = 3;
        drive_frame(-1, -1, 6, -1, -1);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 144 && n0 + i < wq.size(); i++)
            if (wq[n0+i].a !== 16'(i) || wq[n0+i].f !== 3'd0) bad++;
        chk_cnt++;
        if (wq.size() - n0 !== 144 || bad !== 0)
            $display("FAIL busy_start_stream: got %0d writes %0d bad want 144 0", wq.size() - n0, bad);
        else pass_cnt++;
        chk_cnt++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0)
            $display("FAIL busy_start_end: got %0d done busy=%b want 1 0", done_cnt - d0, busy);
        else pass_cnt++;
    endtask

    task automatic test_rst_mid_frame;
        int n0, d0, bad;
        n0 = wq.size(); d0 = done_cnt; bad = 0;
        pulse_start(2, 0);
        drive_frame(-1, -1, -1, -1, -1);
        drive_frame(2, -1, -1, -1, 6);
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (wq.size() - n0 !== 219) $display("FAIL rst_count: got %0d want 219", wq.size() - n0);
        else pass_cnt++;
        for (int i = 0; i < 219 && n0 + i < wq.size(); i++)
            if (wq[n0+i].f !== 3'(i / 144)) bad++;
        chk_cnt++;
        if (bad !== 0) $display("FAIL rst_idx: got %0d bad indices want 0", bad);
        else pass_cnt++;
        chk_cnt++;
        if ({busy, done, err, frame_idx, bus.wr_en, bus.wr_addr, bus.wr_data} !== 33'd0 || done_cnt - d0 !== 0)
            $display("FAIL rst_outputs: got busy=%b err=%b idx=%0d wr_en=%b addr=%0d data=%0d done=%0d want all 0",
                     busy, err, frame_idx, bus.wr_en, bus.wr_addr, bus.wr_data, done_cnt - d0);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_multi_frame;
        test_short_row;
        test_ignored;
        test_long_row_abort;
        test_restart;
        test_start_while_busy;
        test_rst_mid_frame;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
